l2_mac_sequencer: RTL and testbench



---
 rtl/nn_pkg.sv | 24 ++
 rtl/q15_round_sat.sv | 31 +++
 rtl/l2_mac_sequencer.sv | 158 +++++++++++++++
 tb/tb_l2_mac_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM state encoding and saturation limits for the MLP classifier datapath.
package nn_pkg;

  localparam int N_HID     = 8;
  localparam int N_OUT     = 5;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 15;
  localparam int ACC_W     = 35;
  localparam int IDX_W     = 3;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/q15_round_sat.sv
// Accumulator to Q1.15-scaled 16-bit result: round half up, arithmetic shift, clamp.
// Latency: combinational. Backpressure: none.
// Shared between the layer-1 and layer-2 stages.
module q15_round_sat
  import nn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] q
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W-1:0] HI   = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO   = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;

  // acc is bounded well inside ACC_W, so adding the half-LSB cannot overflow
  always_comb begin
    biased  = acc + HALF;
    shifted = biased >>> FRAC_BITS;
    if (shifted > HI) begin
      q = DATA_W'(SAT_MAX);
    end else if (shifted < LO) begin
      q = DATA_W'(SAT_MIN);
    end else begin
      q = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/l2_mac_sequencer.sv
// Layer-2 MAC sequencer: 8-term dot product per output neuron on one multiplier, 5 logits streamed.
// Latency: 8 MAC cycles per logit, 9 per logit with out_ready high. Backpressure: out_valid holds data while !out_ready.
// Optional L2_ARGMAX_EN adds class_id/class_valid (running argmax, ties keep the lower index).
module l2_mac_sequencer
  import nn_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] h_vec,
  output logic [2:0]   rom_addr,
  input  logic [15:0]  w1,
  input  logic [15:0]  w2,
  input  logic [15:0]  w3,
  input  logic [15:0]  w4,
  input  logic [15:0]  w5,
  input  logic [15:0]  w6,
  input  logic [15:0]  w7,
  input  logic [15:0]  w8,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic [2:0]   out_idx,
  output logic         done
`ifdef L2_ARGMAX_EN
  ,
  output logic [2:0]   class_id,
  output logic         class_valid
`endif
);

  state_t                   state;
  logic [N_HID*DATA_W-1:0]  h_q;
  logic [IDX_W-1:0]         k;
  logic [IDX_W-1:0]         n;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] h_sel;
  logic signed [DATA_W-1:0] w_sel;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0] logit;

  always_comb begin
    h_sel = '0;
    w_sel = '0;
    case (k)
      3'd0: begin h_sel = h_q[15:0];    w_sel = w1; end
      3'd1: begin h_sel = h_q[31:16];   w_sel = w2; end
      3'd2: begin h_sel = h_q[47:32];   w_sel = w3; end
      3'd3: begin h_sel = h_q[63:48];   w_sel = w4; end
      3'd4: begin h_sel = h_q[79:64];   w_sel = w5; end
      3'd5: begin h_sel = h_q[95:80];   w_sel = w6; end
      3'd6: begin h_sel = h_q[111:96];  w_sel = w7; end
      default: begin h_sel = h_q[127:112]; w_sel = w8; end
    endcase
  end

  assign prod    = h_sel * w_sel;
  assign acc_nxt = acc + ACC_W'(prod);

  // The final product is folded in combinationally so the logit registers on the last MAC edge
  q15_round_sat u_round (
    .acc (acc_nxt),
    .q   (logit)
  );

`ifdef L2_ARGMAX_EN
  logic signed [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]         max_idx;
  logic                     take_new;

  assign take_new = (out_idx == '0) || ($signed(out_data) > max_val);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_q       <= '0;
      k         <= '0;
      n         <= '0;
      acc       <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
`ifdef L2_ARGMAX_EN
      max_val     <= '0;
      max_idx     <= '0;
      class_id    <= '0;
      class_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef L2_ARGMAX_EN
      class_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            h_q      <= h_vec;
            n        <= '0;
            k        <= '0;
            acc      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= MAC;
          end
        end

        MAC: begin
          acc <= acc_nxt;
          k   <= k + 3'd1;
          if (k == K_LAST) begin
            out_data  <= logit;
            out_idx   <= n;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef L2_ARGMAX_EN
            if (take_new) begin
              max_val <= $signed(out_data);
              max_idx <= out_idx;
            end
`endif
            if (n == N_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`ifdef L2_ARGMAX_EN
              class_id    <= take_new ? out_idx : max_idx;
              class_valid <= 1'b1;
`endif
            end else begin
              n        <= n + 3'd1;
              rom_addr <= n + 3'd1;
              acc      <= '0;
              k        <= '0;
              state    <= MAC;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mac_sequencer.sv
// Bench for l2_mac_sequencer: hand-derived vector table, corner sequences, random jobs vs a dot-product model.
module tb_l2_mac_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] h_vec = '0;
  logic         out_ready = 1'b1;
  logic [2:0]   rom_addr;
  logic [15:0]  w1, w2, w3, w4, w5, w6, w7, w8;
  logic         busy, out_valid, done;
  logic [15:0]  out_data;
  logic [2:0]   out_idx;
`ifdef L2_ARGMAX_EN
  logic [2:0]   class_id;
  logic         class_valid;
`endif

  always #5 clk = ~clk;

  l2_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_vec(h_vec), .rom_addr(rom_addr),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .done(done)
`ifdef L2_ARGMAX_EN
    , .class_id(class_id), .class_valid(class_valid)
`endif
  );

  // Weight ROM contents; idx1 sums to -121151 to force negative saturation
  localparam int ROM [5][8] = '{
    '{-32768, 1000, 2000, 3000, 4000, 5000, 6000, 7000},
    '{-32768, -32768, -32768, -22847, 0, 0, 0, 0},
    '{-9008, 100, -200, 300, -400, 500, -600, 700},
    '{15868, 15000, 15000, 15000, 0, 0, 0, 0},
    '{24784, -1, -2, -3, -4, -5, -6, -7}
  };

  function automatic logic [15:0] rom_w(input logic [2:0] a, input int k);
    int ai;
    ai = int'(a);
    if (ai < 5) return 16'(ROM[ai][k]);
    return '0;
  endfunction

  assign w1 = rom_w(rom_addr, 0);
  assign w2 = rom_w(rom_addr, 1);
  assign w3 = rom_w(rom_addr, 2);
  assign w4 = rom_w(rom_addr, 3);
  assign w5 = rom_w(rom_addr, 4);
  assign w6 = rom_w(rom_addr, 5);
  assign w7 = rom_w(rom_addr, 6);
  assign w8 = rom_w(rom_addr, 7);

  // Reference: exact integer dot product, floor((sum + 2^14) / 2^15), clamp to 16 bits
  function automatic int model_logit(input logic [127:0] h, input int n);
    longint s;
    longint r;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'($signed(h[k*16 +: 16])) * longint'(ROM[n][k]);
    r = (s + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (out_valid && out_idx == 3'd2 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Transfer monitor: sampled mid-cycle, records what the next rising edge transfers
  int got_d[$];
  int got_i[$];
  int got_e[$];
  int done_cnt = 0;
  int stall_cnt = 0;
  bit hold_pend = 0;
  int hold_d = 0;
  int hold_i = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'($signed(out_data)), hold_d);
        chk("hold_idx", int'(out_idx), hold_i);
      end
      hold_pend = out_valid && !out_ready;
      hold_d = int'($signed(out_data));
      hold_i = int'(out_idx);
      if (out_valid) chk("rom_addr_hold", int'(rom_addr), int'(out_idx));
      if (out_valid && !out_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        got_d.push_back(int'($signed(out_data)));
        got_i.push_back(int'(out_idx));
        got_e.push_back(cyc + 1);
      end
      if (done) done_cnt++;
    end else begin
      hold_pend = 0;
    end
  end

  int exp_q[5];
  int exp_cls = 0;
  int start_edge = 0;
  int done_edge = 0;

  task automatic start_job(input logic [127:0] h);
    got_d.delete();
    got_i.delete();
    got_e.delete();
    done_cnt = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    h_vec = h;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = cyc;
    chk("busy_on_start", int'(busy), 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      done_edge = cyc;
      chk("busy_at_done", int'(busy), 0);
`ifdef L2_ARGMAX_EN
      chk("class_valid", int'(class_valid), 1);
      chk("class_id", int'(class_id), exp_cls);
`endif
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done), 0);
      chk("done_count", done_cnt, 1);
`ifdef L2_ARGMAX_EN
      chk("class_valid_drop", int'(class_valid), 0);
`endif
    end
  endtask

  task automatic wait_xfers(input int cnt);
    int t;
    t = 0;
    while (got_d.size() < cnt && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (got_d.size() < cnt) chk("xfer_timeout", got_d.size(), cnt);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, got_d.size(), 5);
    for (int i = 0; i < got_d.size() && i < 5; i++) begin
      chk({tag, "_idx"}, got_i[i], i);
      chk({tag, "_data"}, got_d[i], exp_q[i]);
    end
  endtask

  typedef struct {
    logic [127:0] h;
    int           exp [5];
    int           cls;
  } vec_t;

  vec_t         tbl [4];
  logic [127:0] rh;

  initial begin
    tbl[0].h = 128'h4000;
    tbl[0].exp = '{-16384, -16384, -4504, 7934, 12392};
    tbl[0].cls = 4;
    tbl[1].h = {8{16'h7FFF}};
    tbl[1].exp = '{-4768, -32768, -8608, 32767, 24755};
    tbl[1].cls = 3;
    tbl[2].h = 128'h8000_0000;
    tbl[2].exp = '{-1000, 32767, -100, -15000, 1};
    tbl[2].cls = 1;
    tbl[3].h = '0;
    tbl[3].exp = '{0, 0, 0, 0, 0};
    tbl[3].cls = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_done", int'(done), 0);
`ifdef L2_ARGMAX_EN
    chk("rst_class_id", int'(class_id), 0);
    chk("rst_class_valid", int'(class_valid), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      exp_q = tbl[i].exp;
      exp_cls = tbl[i].cls;
      start_job(tbl[i].h);
      wait_done();
      check_seq("table");
      if (i == 0 && got_e.size() == 5) begin
        chk("first_xfer_edge", got_e[0] - start_edge, 9);
        for (int j = 1; j < 5; j++) chk("xfer_spacing", got_e[j] - got_e[j-1], 9);
        chk("done_edge", done_edge - start_edge, 45);
      end
    end

    // 20-cycle stall on idx2
    exp_q = tbl[0].exp;
    exp_cls = tbl[0].cls;
    ready_mode = 2;
    stall_left = 20;
    start_job(tbl[0].h);
    wait_done();
    check_seq("stall");
    chk("stall_cycles", stall_cnt, 20);
    ready_mode = 0;

    // start pulsed during idx1 MAC must be ignored
    start_job(tbl[0].h);
    wait_xfers(1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    h_vec = tbl[1].h;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    check_seq("busy_start");
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_ignored_start", int'(busy), 0);
    chk("no_extra_logits", got_d.size(), 5);
    chk("no_extra_done", done_cnt, 1);

    // reset in the middle of idx3 MAC
    exp_q = tbl[1].exp;
    exp_cls = tbl[1].cls;
    start_job(tbl[1].h);
    wait_xfers(3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rom_addr", int'(rom_addr), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_out_idx", int'(out_idx), 0);
    chk("abort_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_partial_logits", got_d.size(), 3);
    rst_n = 1'b1;
    start_job(tbl[1].h);
    wait_done();
    check_seq("after_reset");

    // random activations with random backpressure
    ready_mode = 1;
    for (int j = 0; j < 12; j++) begin
      for (int k = 0; k < 8; k++) begin
        if (j % 3 == 0) rh[k*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        else rh[k*16 +: 16] = 16'($urandom);
      end
      exp_cls = 0;
      for (int n = 0; n < 5; n++) begin
        exp_q[n] = model_logit(rh, n);
        if (exp_q[n] > exp_q[exp_cls]) exp_cls = n;
      end
      start_job(rh);
      wait_done();
      check_seq("random");
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
